// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register index, opcodes and the hazard
// controller state encoding.
package rv32i_types;

    typedef logic [4:0] rv32i_reg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        FLUSH_DRAIN = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard-controller bundle: pipeline/cache status in, register load/flush
// controls and performance counters out.
interface hazard_controller_if #(parameter int CNT_WIDTH = 32);

    rv32i_types::rv32i_reg id_ex_src1;
    rv32i_types::rv32i_reg id_ex_src2;
    rv32i_types::rv32i_reg ex_mem_dest;
    logic ex_mem_ld_regfile;
    logic ex_mem_dmem_read;
    logic id_ex_uses_src2;
    logic br_mispredict;

    // Cache handshake: a read/write request is held high until its resp,
    // and resp is a single-cycle completion strobe for that request.
    logic imem_read;
    logic imem_resp;
    logic dmem_read;
    logic dmem_write;
    logic dmem_resp;

    logic ld_pc;
    logic ld_if_id;
    logic ld_id_ex;
    logic ld_ex_mem;
    logic ld_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic bubble_ex_mem;
    logic pc_redirect;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output id_ex_src1, id_ex_src2, ex_mem_dest, ex_mem_ld_regfile,
               ex_mem_dmem_read, id_ex_uses_src2, br_mispredict,
               imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        input  ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
               flush_if_id, flush_id_ex, bubble_ex_mem, pc_redirect,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_ex_src1, id_ex_src2, ex_mem_dest, ex_mem_ld_regfile,
               ex_mem_dmem_read, id_ex_uses_src2, br_mispredict,
               imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        output ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
               flush_if_id, flush_id_ex, bubble_ex_mem, pc_redirect,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: cache-miss stalls, branch flushes
// and load-use bubbles, with saturating stall/flush counters.
module hazard_controller
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  hz,
    output hazard_state_t       state
);

    hazard_state_t state_n;
    logic imem_done, dmem_done;
    logic imem_done_n, dmem_done_n;
    logic dmem_act, imem_stall, dmem_stall;
    logic imem_ok, dmem_ok, load_use;
    logic stall_inc, flush_inc;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    assign dmem_act   = hz.dmem_read | hz.dmem_write;
    assign imem_stall = hz.imem_read & ~hz.imem_resp;
    assign dmem_stall = dmem_act & ~hz.dmem_resp;
    assign imem_ok    = ~hz.imem_read | imem_done | hz.imem_resp;
    assign dmem_ok    = ~dmem_act | dmem_done | hz.dmem_resp;

    assign load_use = hz.ex_mem_dmem_read & hz.ex_mem_ld_regfile
                    & (hz.ex_mem_dest != '0)
                    & ((hz.ex_mem_dest == hz.id_ex_src1)
                       | (hz.id_ex_uses_src2 & (hz.ex_mem_dest == hz.id_ex_src2)));

    always_comb begin
        state_n          = state;
        imem_done_n      = imem_done;
        dmem_done_n      = dmem_done;
        flush_inc        = 1'b0;
        hz.ld_pc         = 1'b0;
        hz.ld_if_id      = 1'b0;
        hz.ld_id_ex      = 1'b0;
        hz.ld_ex_mem     = 1'b0;
        hz.ld_mem_wb     = 1'b0;
        hz.flush_if_id   = 1'b0;
        hz.flush_id_ex   = 1'b0;
        hz.bubble_ex_mem = 1'b0;
        hz.pc_redirect   = 1'b0;
        if (rst) begin
            unique case (state)
                RUN: begin
                    // An instruction-only miss under a mispredict is redirected
                    // at once; the wrong-path fetch is drained afterwards.
                    if (dmem_stall || (imem_stall && !hz.br_mispredict)) begin
                        state_n     = MEM_WAIT;
                        imem_done_n = hz.imem_read & hz.imem_resp;
                        dmem_done_n = dmem_act & hz.dmem_resp;
                    end else if (hz.br_mispredict) begin
                        {hz.ld_pc, hz.ld_if_id, hz.ld_id_ex, hz.ld_ex_mem, hz.ld_mem_wb} = '1;
                        hz.pc_redirect = 1'b1;
                        hz.flush_if_id = 1'b1;
                        hz.flush_id_ex = 1'b1;
                        flush_inc      = 1'b1;
                        if (imem_stall) state_n = FLUSH_DRAIN;
                    end else if (load_use) begin
                        hz.ld_ex_mem     = 1'b1;
                        hz.bubble_ex_mem = 1'b1;
                        hz.ld_mem_wb     = 1'b1;
                    end else begin
                        {hz.ld_pc, hz.ld_if_id, hz.ld_id_ex, hz.ld_ex_mem, hz.ld_mem_wb} = '1;
                    end
                end
                MEM_WAIT: begin
                    if (imem_ok && dmem_ok) begin
                        {hz.ld_pc, hz.ld_if_id, hz.ld_id_ex, hz.ld_ex_mem, hz.ld_mem_wb} = '1;
                        imem_done_n = 1'b0;
                        dmem_done_n = 1'b0;
                        state_n     = RUN;
                        if (hz.br_mispredict) begin
                            hz.pc_redirect = 1'b1;
                            hz.flush_if_id = 1'b1;
                            hz.flush_id_ex = 1'b1;
                            flush_inc      = 1'b1;
                        end
                    end else begin
                        imem_done_n = imem_done | (hz.imem_read & hz.imem_resp);
                        dmem_done_n = dmem_done | (dmem_act & hz.dmem_resp);
                    end
                end
                FLUSH_DRAIN: begin
                    hz.ld_id_ex  = ~dmem_stall;
                    hz.ld_ex_mem = ~dmem_stall;
                    hz.ld_mem_wb = ~dmem_stall;
                    if (hz.imem_resp) begin
                        hz.ld_pc       = 1'b1;
                        hz.ld_if_id    = 1'b1;
                        hz.flush_if_id = 1'b1;
                        state_n        = RUN;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
        end else begin
            state     <= state_n;
            imem_done <= imem_done_n;
            dmem_done <= dmem_done_n;
        end
    end

    assign stall_inc = ~hz.ld_pc;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with 4-bit counters so saturation is
// reachable in a few cycles.
module tb_hazard_controller;
    import rv32i_types::*;

    localparam int CW = 4;

    logic clk;
    logic rst;
    hazard_state_t state;
    int total;
    int bad;

    hazard_controller_if #(.CNT_WIDTH(CW)) hz ();

    hazard_controller #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz    (hz.slave),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ld = {pc, if_id, id_ex, ex_mem, mem_wb}; ctl = {flush_if_id, flush_id_ex, bubble, redirect}
    task automatic chk_out(input string tag, input logic [4:0] exp_ld, input logic [3:0] exp_ctl);
        chk({tag, ".ld"}, 32'({hz.ld_pc, hz.ld_if_id, hz.ld_id_ex, hz.ld_ex_mem, hz.ld_mem_wb}), 32'(exp_ld));
        chk({tag, ".ctl"}, 32'({hz.flush_if_id, hz.flush_id_ex, hz.bubble_ex_mem, hz.pc_redirect}), 32'(exp_ctl));
    endtask

    task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush, input hazard_state_t exp_st);
        chk({tag, ".stall"}, 32'(hz.stall_cycles), 32'(exp_stall));
        chk({tag, ".flush"}, 32'(hz.flush_count), 32'(exp_flush));
        chk({tag, ".state"}, 32'(state), 32'(exp_st));
    endtask

    task automatic idle();
        hz.id_ex_src1 = 5'd0;
        hz.id_ex_src2 = 5'd0;
        hz.ex_mem_dest = 5'd0;
        hz.ex_mem_ld_regfile = 1'b0;
        hz.ex_mem_dmem_read = 1'b0;
        hz.id_ex_uses_src2 = 1'b0;
        hz.br_mispredict = 1'b0;
        hz.imem_read = 1'b0;
        hz.imem_resp = 1'b0;
        hz.dmem_read = 1'b0;
        hz.dmem_write = 1'b0;
        hz.dmem_resp = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic set_load(input logic [4:0] dest, input logic [4:0] s1, input logic [4:0] s2, input logic use2);
        hz.ex_mem_dest = dest;
        hz.ex_mem_ld_regfile = 1'b1;
        hz.ex_mem_dmem_read = 1'b1;
        hz.id_ex_src1 = s1;
        hz.id_ex_src2 = s2;
        hz.id_ex_uses_src2 = use2;
    endtask

    initial begin
        total = 0;
        bad = 0;
        idle();

        // Reset with a live hazard on the inputs: everything must stay quiet.
        rst = 1'b0;
        set_load(5'd5, 5'd5, 5'd0, 1'b0);
        hz.dmem_read = 1'b1;
        #2;
        chk_out("reset", 5'b00000, 4'b0000);
        chk_cnt("reset", 0, 0, RUN);
        tick();
        chk_cnt("reset_hold", 0, 0, RUN);
        do_reset();

        chk_out("normal", 5'b11111, 4'b0000);
        tick();
        chk_cnt("normal", 0, 0, RUN);

        // Load-use on src1 (x5).
        set_load(5'd5, 5'd5, 5'd0, 1'b0);
        #1;
        chk_out("lu_src1", 5'b00011, 4'b0010);
        tick();
        idle();
        #1;
        chk_cnt("lu_src1", 1, 0, RUN);
        chk_out("lu_after", 5'b11111, 4'b0000);
        tick();

        // Load-use on src2, counted only when rs2 is really read.
        set_load(5'd7, 5'd3, 5'd7, 1'b1);
        #1;
        chk_out("lu_src2", 5'b00011, 4'b0010);
        tick();
        set_load(5'd7, 5'd3, 5'd7, 1'b0);
        #1;
        chk_out("lu_src2_unused", 5'b11111, 4'b0000);
        tick();

        // Destination x0 never stalls; a non-writing load never stalls.
        set_load(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        chk_out("lu_x0", 5'b11111, 4'b0000);
        tick();
        set_load(5'd9, 5'd9, 5'd0, 1'b0);
        hz.ex_mem_ld_regfile = 1'b0;
        #1;
        chk_out("lu_noreg", 5'b11111, 4'b0000);
        tick();
        idle();
        #1;
        chk_cnt("lu_total", 2, 0, RUN);

        // dmem miss resolves after 4 cycles, imem after 2.
        do_reset();
        hz.imem_read = 1'b1;
        hz.dmem_read = 1'b1;
        for (int c = 0; c < 5; c++) begin
            hz.imem_resp = (c == 2);
            hz.dmem_resp = (c == 4);
            #1;
            chk_out($sformatf("memwait_c%0d", c), (c == 4) ? 5'b11111 : 5'b00000, 4'b0000);
            chk($sformatf("memwait_st%0d", c), 32'(state), (c == 0) ? 32'(RUN) : 32'(MEM_WAIT));
            tick();
        end
        idle();
        #1;
        chk_cnt("memwait_done", 4, 0, RUN);

        // Mispredict with an outstanding fetch; resp three cycles later,
        // with a data miss blocking downstream in the middle drain cycle.
        do_reset();
        hz.br_mispredict = 1'b1;
        hz.imem_read = 1'b1;
        #1;
        chk_out("br_redirect", 5'b11111, 4'b1101);
        tick();
        hz.br_mispredict = 1'b0;
        #1;
        chk_out("drain1", 5'b00111, 4'b0000);
        chk("drain1.state", 32'(state), 32'(FLUSH_DRAIN));
        tick();
        hz.dmem_read = 1'b1;
        #1;
        chk_out("drain2_dmiss", 5'b00000, 4'b0000);
        tick();
        hz.dmem_read = 1'b0;
        hz.imem_resp = 1'b1;
        #1;
        chk_out("drain_resp", 5'b11111, 4'b1000);
        tick();
        idle();
        #1;
        chk_cnt("drain_done", 2, 1, RUN);

        // Mispredict and load-use together: flush only, no stall counted.
        do_reset();
        set_load(5'd5, 5'd5, 5'd0, 1'b0);
        hz.br_mispredict = 1'b1;
        #1;
        chk_out("br_lu", 5'b11111, 4'b1101);
        tick();
        idle();
        #1;
        chk_cnt("br_lu", 0, 1, RUN);

        // Reset pulse while in MEM_WAIT, then a stray late dmem_resp.
        hz.dmem_read = 1'b1;
        #1;
        tick();
        chk("mw_entered", 32'(state), 32'(MEM_WAIT));
        rst = 1'b0;
        #1;
        chk_out("mw_reset", 5'b00000, 4'b0000);
        chk_cnt("mw_reset", 0, 0, RUN);
        idle();
        hz.dmem_resp = 1'b1;
        rst = 1'b1;
        #1;
        chk_out("late_resp", 5'b11111, 4'b0000);
        tick();
        hz.dmem_resp = 1'b0;
        #1;
        chk_cnt("late_resp", 0, 0, RUN);

        // Reset pulse while in FLUSH_DRAIN.
        hz.br_mispredict = 1'b1;
        hz.imem_read = 1'b1;
        tick();
        hz.br_mispredict = 1'b0;
        #1;
        chk("fd_entered", 32'(state), 32'(FLUSH_DRAIN));
        rst = 1'b0;
        #1;
        chk_out("fd_reset", 5'b00000, 4'b0000);
        chk_cnt("fd_reset", 0, 0, RUN);
        do_reset();

        // Saturation: 20 stalled cycles on a 4-bit counter.
        hz.dmem_read = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k >= 14) chk($sformatf("sat_k%0d", k), 32'(hz.stall_cycles), (k < 15) ? 32'(k) : 32'd15);
        end
        idle();
        hz.dmem_read = 1'b1;
        hz.dmem_resp = 1'b1;
        #1;
        chk_out("sat_release", 5'b11111, 4'b0000);
        tick();
        idle();
        #1;
        chk_cnt("sat_final", 15, 0, RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
